// File: rtl/complex_mag_pkg.sv
// Shared constants for the complex magnitude estimator and its moving-average stage.
package complex_mag_pkg;

  localparam logic [1:0] MODE_AMBM_Q     = 2'd0;
  localparam logic [1:0] MODE_AMBM_3_8   = 2'd1;
  localparam logic [1:0] MODE_AMBM_15_16 = 2'd2;
  localparam logic [1:0] MODE_POWER      = 2'd3;

  localparam int unsigned LOG_WIN_MIN = 1;
  localparam int unsigned LOG_WIN_MAX = 8;

endpackage

// File: rtl/mag_moving_avg.sv
// Windowed mean of a magnitude stream; the window restarts whenever the sample mode changes.
module mag_moving_avg
  import complex_mag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG_WIN    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] mag,
  input  logic [1:0]            mag_mode,
  input  logic                  mag_stb,
  output logic [DATA_WIDTH-1:0] avg,
  output logic                  avg_stb
);

  localparam int unsigned WIN   = 1 << LOG_WIN;
  localparam int unsigned SUM_W = DATA_WIDTH + LOG_WIN;
  localparam logic [LOG_WIN:0] FILL_FULL = {1'b1, {LOG_WIN{1'b0}}};

  logic [DATA_WIDTH-1:0] win_q [WIN];
  logic [LOG_WIN-1:0]    wr_ptr_q, wr_ptr_d, wr_idx;
  logic [LOG_WIN:0]      fill_q, fill_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [1:0]            last_mode_q, last_mode_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic                  avg_stb_q, avg_stb_d;

  always_comb begin
    sum_d       = sum_q;
    fill_d      = fill_q;
    wr_idx      = wr_ptr_q;
    last_mode_d = last_mode_q;
    avg_d       = avg_q;
    avg_stb_d   = 1'b0;
    if (mag_stb) begin
      last_mode_d = mag_mode;
      if (mag_mode != last_mode_q) begin
        // Stale entries are abandoned, not subtracted: the new mode starts a fresh window.
        sum_d  = SUM_W'(mag);
        fill_d = (LOG_WIN+1)'(1);
        wr_idx = '0;
      end else if (fill_q == FILL_FULL) begin
        sum_d = sum_q + SUM_W'(mag) - SUM_W'(win_q[wr_ptr_q]);
      end else begin
        sum_d  = sum_q + SUM_W'(mag);
        fill_d = fill_q + (LOG_WIN+1)'(1);
      end
      avg_stb_d = (fill_d == FILL_FULL);
      if (avg_stb_d) begin
        avg_d = sum_d[SUM_W-1:LOG_WIN];
      end
    end
    wr_ptr_d = mag_stb ? wr_idx + LOG_WIN'(1) : wr_ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < WIN; k++) begin
        win_q[k] <= '0;
      end
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      last_mode_q <= MODE_AMBM_Q;
      avg_q       <= '0;
      avg_stb_q   <= 1'b0;
    end else if (enable) begin
      if (mag_stb) begin
        win_q[wr_idx] <= mag;
      end
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      last_mode_q <= last_mode_d;
      avg_q       <= avg_d;
      avg_stb_q   <= avg_stb_d;
    end
  end

  assign avg     = avg_q;
  assign avg_stb = avg_stb_q;

endmodule

// File: rtl/complex_mag_est.sv
// Three-stage I/Q magnitude estimator with four selectable estimators plus a windowed mean.
module complex_mag_est
  import complex_mag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG_WIN    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] i,
  input  logic signed [DATA_WIDTH-1:0] q,
  input  logic                         input_strobe,
  output logic [DATA_WIDTH-1:0]        mag,
  output logic                         mag_stb,
  output logic [DATA_WIDTH-1:0]        avg,
  output logic                         avg_stb
);

  localparam int unsigned DW = DATA_WIDTH;

  if (LOG_WIN < LOG_WIN_MIN || LOG_WIN > LOG_WIN_MAX) begin : g_bad_log_win
    $error("complex_mag_est: LOG_WIN out of range");
  end

  logic [DW-1:0]   abs_i_d, abs_q_d;
  logic [DW-1:0]   s1_abs_i_q, s1_abs_q_q;
  logic [1:0]      s1_mode_q;
  logic            s1_stb_q;
  logic [DW-1:0]   max_d, min_d;
  logic [2*DW-1:0] sq_i_d, sq_q_d;
  logic [DW-1:0]   s2_max_q, s2_min_q;
  logic [2*DW-1:0] s2_sq_i_q, s2_sq_q_q;
  logic [1:0]      s2_mode_q;
  logic            s2_stb_q;
  logic [DW:0]     mx, mn, comb;
  logic [2*DW-1:0] pwr_sum;
  logic            unused_pwr_lsbs;
  logic [DW-1:0]   mag_d, mag_q;
  logic [1:0]      mag_mode_q;
  logic            mag_stb_q;

  // Negating the most negative value yields 2^(DW-1) when read back as unsigned.
  assign abs_i_d = i[DW-1] ? $unsigned(-i) : $unsigned(i);
  assign abs_q_d = q[DW-1] ? $unsigned(-q) : $unsigned(q);

  assign max_d  = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_i_q : s1_abs_q_q;
  assign min_d  = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_q_q : s1_abs_i_q;
  assign sq_i_d = {{DW{1'b0}}, s1_abs_i_q} * {{DW{1'b0}}, s1_abs_i_q};
  assign sq_q_d = {{DW{1'b0}}, s1_abs_q_q} * {{DW{1'b0}}, s1_abs_q_q};

  // Each square is at most 2^(2DW-2), so the sum needs no carry bit.
  assign pwr_sum         = s2_sq_i_q + s2_sq_q_q;
  assign unused_pwr_lsbs = ^pwr_sum[DW-2:0];

  always_comb begin
    mx   = {1'b0, s2_max_q};
    mn   = {1'b0, s2_min_q};
    comb = '0;
    case (s2_mode_q)
      MODE_AMBM_Q:     comb = mx + (mn >> 2);
      MODE_AMBM_3_8:   comb = mx + (((mn << 1) + mn) >> 3);
      MODE_AMBM_15_16: comb = mx - (mx >> 4) + (mn >> 1) - (mn >> 5);
      default:         comb = pwr_sum[2*DW-1:DW-1];
    endcase
    // Only the power path can set the top bit, so this clamp is a no-op for modes 0-2.
    mag_d = comb[DW] ? '1 : comb[DW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_abs_i_q <= '0;
      s1_abs_q_q <= '0;
      s1_mode_q  <= '0;
      s1_stb_q   <= 1'b0;
      s2_max_q   <= '0;
      s2_min_q   <= '0;
      s2_sq_i_q  <= '0;
      s2_sq_q_q  <= '0;
      s2_mode_q  <= '0;
      s2_stb_q   <= 1'b0;
      mag_q      <= '0;
      mag_mode_q <= '0;
      mag_stb_q  <= 1'b0;
    end else if (enable) begin
      s1_abs_i_q <= abs_i_d;
      s1_abs_q_q <= abs_q_d;
      s1_mode_q  <= mode;
      s1_stb_q   <= input_strobe;
      s2_max_q   <= max_d;
      s2_min_q   <= min_d;
      s2_sq_i_q  <= sq_i_d;
      s2_sq_q_q  <= sq_q_d;
      s2_mode_q  <= s1_mode_q;
      s2_stb_q   <= s1_stb_q;
      mag_q      <= mag_d;
      mag_mode_q <= s2_mode_q;
      mag_stb_q  <= s2_stb_q;
    end
  end

  assign mag     = mag_q;
  assign mag_stb = mag_stb_q;

  mag_moving_avg #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG_WIN   (LOG_WIN)
  ) u_avg (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .mag     (mag_q),
    .mag_mode(mag_mode_q),
    .mag_stb (mag_stb_q),
    .avg     (avg),
    .avg_stb (avg_stb)
  );

endmodule

// File: tb/tb_complex_mag_est.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor checks each output strobe.
module tb_complex_mag_est;

  localparam int unsigned DW = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [1:0]           mode;
  logic signed [DW-1:0] i, q;
  logic                 input_strobe;
  logic [DW-1:0]        mag, avg;
  logic                 mag_stb, avg_stb;

  typedef struct {
    logic [DW-1:0] val;
    int            edge_n;
  } mag_exp_t;

  mag_exp_t      mag_exp[$];
  logic [DW-1:0] avg_exp[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            en_edges = 0;

  complex_mag_est #(
    .DATA_WIDTH(DW),
    .LOG_WIN   (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .i           (i),
    .q           (q),
    .input_strobe(input_strobe),
    .mag         (mag),
    .mag_stb     (mag_stb),
    .avg         (avg),
    .avg_stb     (avg_stb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected mag emerges on the third enabled edge after the sample is driven.
  task automatic send(input int ii, input int qq, input logic [1:0] md, input int exp_mag);
    mag_exp_t e;
    i            = ii[DW-1:0];
    q            = qq[DW-1:0];
    mode         = md;
    input_strobe = 1'b1;
    e.val        = exp_mag[DW-1:0];
    e.edge_n     = en_edges + 3;
    mag_exp.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    input_strobe = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    input_strobe = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mag_exp.delete();
    avg_exp.delete();
    chk({name, "_mag"}, 32'(mag), 32'd0);
    chk({name, "_mag_stb"}, 32'(mag_stb), 32'd0);
    chk({name, "_avg"}, 32'(avg), 32'd0);
    chk({name, "_avg_stb"}, 32'(avg_stb), 32'd0);
  endtask

  // Monitor: only edges taken with enable high and reset low can produce a new pulse.
  initial begin
    logic     en_s, rst_s;
    mag_exp_t e;
    forever begin
      @(posedge clock);
      en_s  = enable;
      rst_s = reset;
      if (en_s && !rst_s) en_edges++;
      @(negedge clock);
      if (en_s && !rst_s) begin
        if (mag_stb) begin
          if (mag_exp.size() == 0) begin
            chk("unexpected_mag_stb", 32'd1, 32'd0);
          end else begin
            e = mag_exp.pop_front();
            chk("mag_value", 32'(mag), 32'(e.val));
            chk("mag_latency", 32'(en_edges), 32'(e.edge_n));
          end
        end
        if (avg_stb) begin
          if (avg_exp.size() == 0) begin
            chk("unexpected_avg_stb", 32'd1, 32'd0);
          end else begin
            chk("avg_value", 32'(avg), 32'(avg_exp.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    reset        = 1'b1;
    enable       = 1'b1;
    mode         = 2'd0;
    i            = '0;
    q            = '0;
    input_strobe = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_mag", 32'(mag), 32'd0);
    chk("reset_mag_stb", 32'(mag_stb), 32'd0);
    chk("reset_avg", 32'(avg), 32'd0);
    chk("reset_avg_stb", 32'(avg_stb), 32'd0);

    // Mode 0 basics, back to back.
    send(3, -4, 2'd0, 4);
    send(-32768, 0, 2'd0, 32768);
    idle(5);

    // Estimator comparison and power saturation; every mode change restarts the window.
    do_reset("rst_b");
    send(3, -4, 2'd1, 5);
    send(3, -4, 2'd2, 5);
    send(1000, 0, 2'd3, 30);
    send(-32768, -32768, 2'd3, 65535);
    idle(5);

    // Window fill, slide, then flush on switching to mode 1.
    do_reset("rst_c");
    send(4, 0, 2'd0, 4);
    send(8, 0, 2'd0, 8);
    send(12, 0, 2'd0, 12);
    avg_exp.push_back(16'd10);
    send(16, 0, 2'd0, 16);
    avg_exp.push_back(16'd14);
    send(20, 0, 2'd0, 20);
    idle(2);
    send(8, 0, 2'd1, 8);
    send(16, 0, 2'd1, 16);
    send(24, 0, 2'd1, 24);
    avg_exp.push_back(16'd20);
    send(0, 32, 2'd1, 32);
    idle(5);

    // Enable freeze: sample sits in the pipe while enable is low.
    send(7, 0, 2'd0, 7);
    input_strobe = 1'b0;
    enable       = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("frozen_mag_stb", 32'(mag_stb), 32'd0);
    chk("frozen_avg_stb", 32'(avg_stb), 32'd0);
    enable = 1'b1;
    idle(5);

    // Two samples in flight when reset hits: neither may emerge.
    i            = 16'sd100;
    q            = 16'sd0;
    mode         = 2'd0;
    input_strobe = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    do_reset("rst_e");
    idle(4);
    send(12, 0, 2'd0, 12);
    send(0, -12, 2'd0, 12);
    send(-12, 0, 2'd0, 12);
    avg_exp.push_back(16'd12);
    send(12, 0, 2'd0, 12);
    idle(3);

    waited = 0;
    while ((mag_exp.size() != 0 || avg_exp.size() != 0) && waited < 20) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("drain_mag_queue", 32'(mag_exp.size()), 32'd0);
    chk("drain_avg_queue", 32'(avg_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
